// File: rtl/tdm_demux_rx.sv
// tdm_demux_rx: four-slot TDM demultiplexer with HUNT/LOCKED frame tracking.
// Optional feature macro TDM_FRAME_LATCH_EN: stage slots 0..2 internally and
// publish all four channels together when slot 3 is accepted.
module tdm_demux_rx #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] din,
  input  logic         din_valid,
  input  logic         frame_sync,
  output logic [W-1:0] ch0,
  output logic [W-1:0] ch1,
  output logic [W-1:0] ch2,
  output logic [W-1:0] ch3,
  output logic [3:0]   ch_valid,
  output logic         frame_done,
  output logic         locked,
  output logic         sync_err
);

  localparam int unsigned NCH = 4;

  typedef enum logic {
    ST_HUNT   = 1'b0,
    ST_LOCKED = 1'b1
  } state_e;

  state_e      state_q, state_d;
  logic [1:0]  slot_q, slot_d;
  logic        accept;
  logic [1:0]  acc_slot;
  logic        err;

  logic [W-1:0] ch_q [NCH];
  logic [3:0]   ch_valid_q;
  logic         frame_done_q;
  logic         sync_err_q;
`ifdef TDM_FRAME_LATCH_EN
  logic [W-1:0] stage_q [NCH-1];
`endif

  // State and slot counter register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_HUNT;
      slot_q  <= 2'd0;
    end else begin
      state_q <= state_d;
      slot_q  <= slot_d;
    end
  end

  // Next-state: enter LOCKED on a sync beat, fall back to HUNT on a missing sync
  always_comb begin
    state_d = state_q;
    if (din_valid) begin
      unique case (state_q)
        ST_HUNT:   if (frame_sync) state_d = ST_LOCKED;
        ST_LOCKED: if (!frame_sync && (slot_q == 2'd0)) state_d = ST_HUNT;
        default:   state_d = ST_HUNT;
      endcase
    end
  end

  // Beat classification: accept/discard, target slot, framing error, next slot
  always_comb begin
    accept   = 1'b0;
    acc_slot = slot_q;
    err      = 1'b0;
    slot_d   = slot_q;
    if (din_valid) begin
      if (state_q == ST_HUNT) begin
        if (frame_sync) begin
          accept   = 1'b1;
          acc_slot = 2'd0;
          slot_d   = 2'd1;
        end
      end else if (frame_sync) begin
        // Sync beat always restarts the frame; early sync is flagged
        accept   = 1'b1;
        acc_slot = 2'd0;
        slot_d   = 2'd1;
        err      = (slot_q != 2'd0);
      end else if (slot_q != 2'd0) begin
        accept   = 1'b1;
        slot_d   = slot_q + 2'd1;
      end else begin
        // Expected a sync beat at slot 0 and did not get one
        err      = 1'b1;
        slot_d   = 2'd0;
      end
    end
  end

  // Registered channel data, valid strobes and status pulses
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(NCH); i++) ch_q[i] <= '0;
`ifdef TDM_FRAME_LATCH_EN
      for (int i = 0; i < int'(NCH) - 1; i++) stage_q[i] <= '0;
`endif
      ch_valid_q   <= 4'b0000;
      frame_done_q <= 1'b0;
      sync_err_q   <= 1'b0;
    end else begin
      ch_valid_q   <= 4'b0000;
      frame_done_q <= accept && (acc_slot == 2'd3);
      sync_err_q   <= err;
      if (accept) begin
`ifdef TDM_FRAME_LATCH_EN
        if (acc_slot == 2'd3) begin
          ch_q[0]    <= stage_q[0];
          ch_q[1]    <= stage_q[1];
          ch_q[2]    <= stage_q[2];
          ch_q[3]    <= din;
          ch_valid_q <= 4'b1111;
        end else begin
          stage_q[acc_slot] <= din;
        end
`else
        ch_q[acc_slot] <= din;
        ch_valid_q     <= 4'b0001 << acc_slot;
`endif
      end
    end
  end

  assign ch0        = ch_q[0];
  assign ch1        = ch_q[1];
  assign ch2        = ch_q[2];
  assign ch3        = ch_q[3];
  assign ch_valid   = ch_valid_q;
  assign frame_done = frame_done_q;
  assign sync_err   = sync_err_q;
  assign locked     = (state_q == ST_LOCKED);

endmodule

// File: tb/tb_tdm_demux_rx.sv
// Testbench for tdm_demux_rx: directed framing scenarios plus random traffic,
// all checked against a frame-level reference model.
module tb_tdm_demux_rx;

  localparam int unsigned W = 8;

  logic         clk;
  logic         rst;
  logic [W-1:0] din;
  logic         din_valid;
  logic         frame_sync;
  logic [W-1:0] ch0, ch1, ch2, ch3;
  logic [3:0]   ch_valid;
  logic         frame_done;
  logic         locked;
  logic         sync_err;

  int n_vec;
  int n_err;

  // Reference model state
  bit           m_locked;
  int           m_next;       // slot index the next in-frame beat belongs to
  logic [W-1:0] m_ch    [4];
  logic [W-1:0] m_stage [4];
  logic [3:0]   e_valid;
  bit           e_done;
  bit           e_err;

  tdm_demux_rx #(.W(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .din        (din),
    .din_valid  (din_valid),
    .frame_sync (frame_sync),
    .ch0        (ch0),
    .ch1        (ch1),
    .ch2        (ch2),
    .ch3        (ch3),
    .ch_valid   (ch_valid),
    .frame_done (frame_done),
    .locked     (locked),
    .sync_err   (sync_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Hand a beat to the model for slot s
  task automatic model_deliver(input int s, input logic [W-1:0] d);
`ifdef TDM_FRAME_LATCH_EN
    m_stage[s] = d;
    if (s == 3) begin
      for (int i = 0; i < 4; i++) m_ch[i] = m_stage[i];
      e_valid = 4'b1111;
      e_done  = 1'b1;
    end
`else
    m_ch[s]    = d;
    e_valid[s] = 1'b1;
    e_done     = (s == 3);
`endif
  endtask

  task automatic model_step(input bit r, input bit v, input bit fs, input logic [W-1:0] d);
    e_valid = 4'b0000;
    e_done  = 1'b0;
    e_err   = 1'b0;
    if (r) begin
      m_locked = 1'b0;
      m_next   = 0;
      for (int i = 0; i < 4; i++) begin
        m_ch[i]    = '0;
        m_stage[i] = '0;
      end
    end else if (v) begin
      if (!m_locked) begin
        if (fs) begin
          model_deliver(0, d);
          m_next   = 1;
          m_locked = 1'b1;
        end
      end else if (fs) begin
        e_err = (m_next != 0);
        model_deliver(0, d);
        m_next = 1;
      end else if (m_next != 0) begin
        model_deliver(m_next, d);
        m_next = (m_next + 1) % 4;
      end else begin
        e_err    = 1'b1;
        m_locked = 1'b0;
      end
    end
  endtask

  // Drive one cycle, advance the model, then compare every output
  task automatic apply(input bit r, input bit v, input bit fs, input logic [W-1:0] d);
    rst        = r;
    din_valid  = v;
    frame_sync = fs;
    din        = d;
    @(posedge clk);
    model_step(r, v, fs, d);
    #1;
    check_eq("ch0",        32'(ch0),        32'(m_ch[0]));
    check_eq("ch1",        32'(ch1),        32'(m_ch[1]));
    check_eq("ch2",        32'(ch2),        32'(m_ch[2]));
    check_eq("ch3",        32'(ch3),        32'(m_ch[3]));
    check_eq("ch_valid",   32'(ch_valid),   32'(e_valid));
    check_eq("frame_done", 32'(frame_done), 32'(e_done));
    check_eq("locked",     32'(locked),     32'(m_locked));
    check_eq("sync_err",   32'(sync_err),   32'(e_err));
  endtask

  task automatic do_reset();
    apply(1'b1, 1'b0, 1'b0, 8'h00);
    apply(1'b1, 1'b1, 1'b1, 8'hA5);
  endtask

  task automatic gap(input int n);
    for (int i = 0; i < n; i++) apply(1'b0, 1'b0, 1'b0, 8'($urandom));
  endtask

  initial begin
    n_vec      = 0;
    n_err      = 0;
    rst        = 1'b1;
    din        = '0;
    din_valid  = 1'b0;
    frame_sync = 1'b0;
    m_locked   = 1'b0;
    m_next     = 0;
    for (int i = 0; i < 4; i++) begin
      m_ch[i]    = '0;
      m_stage[i] = '0;
    end

    // Reset state
    do_reset();
    check_eq("rst_locked", 32'(locked), 32'd0);
    check_eq("rst_ch0",    32'(ch0),    32'd0);

    // Basic frame
    apply(1'b0, 1'b1, 1'b1, 8'd10);
    apply(1'b0, 1'b1, 1'b0, 8'd12);
    apply(1'b0, 1'b1, 1'b0, 8'd15);
    apply(1'b0, 1'b1, 1'b0, 8'd8);
`ifndef TDM_FRAME_LATCH_EN
    check_eq("basic_ch0",   32'(ch0),        32'd10);
    check_eq("basic_ch1",   32'(ch1),        32'd12);
    check_eq("basic_ch2",   32'(ch2),        32'd15);
    check_eq("basic_ch3",   32'(ch3),        32'd8);
    check_eq("basic_valid", 32'(ch_valid),   32'h8);
    check_eq("basic_done",  32'(frame_done), 32'd1);
    check_eq("basic_lock",  32'(locked),     32'd1);
`endif

    // Hunt: unsynced beats ignored
    do_reset();
    apply(1'b0, 1'b1, 1'b0, 8'd7);
    apply(1'b0, 1'b1, 1'b0, 8'd9);
    check_eq("hunt_ch0",  32'(ch0),    32'd0);
    check_eq("hunt_lock", 32'(locked), 32'd0);
    apply(1'b0, 1'b1, 1'b1, 8'd11);
    apply(1'b0, 1'b1, 1'b0, 8'd14);
    apply(1'b0, 1'b1, 1'b0, 8'd13);
    apply(1'b0, 1'b1, 1'b0, 8'd10);
`ifndef TDM_FRAME_LATCH_EN
    check_eq("hunt_ch0b", 32'(ch0), 32'd11);
    check_eq("hunt_ch3",  32'(ch3), 32'd10);
`endif

    // Early sync resync
    do_reset();
    apply(1'b0, 1'b1, 1'b1, 8'd20);
    apply(1'b0, 1'b1, 1'b0, 8'd21);
    apply(1'b0, 1'b1, 1'b1, 8'd5);
    check_eq("early_err",  32'(sync_err), 32'd1);
    check_eq("early_lock", 32'(locked),   32'd1);
`ifndef TDM_FRAME_LATCH_EN
    check_eq("early_ch0",  32'(ch0),      32'd5);
`endif
    apply(1'b0, 1'b1, 1'b0, 8'd6);
`ifndef TDM_FRAME_LATCH_EN
    check_eq("early_ch1",  32'(ch1),      32'd6);
`endif

    // Missing sync after a full frame
    do_reset();
    apply(1'b0, 1'b1, 1'b1, 8'd1);
    apply(1'b0, 1'b1, 1'b0, 8'd2);
    apply(1'b0, 1'b1, 1'b0, 8'd3);
    apply(1'b0, 1'b1, 1'b0, 8'd4);
    apply(1'b0, 1'b1, 1'b0, 8'd3);
    check_eq("miss_err",  32'(sync_err), 32'd1);
    check_eq("miss_lock", 32'(locked),   32'd0);
    check_eq("miss_ch0",  32'(ch0),      32'(m_ch[0]));

    // Gaps between slots, then reset mid-frame with a colliding beat
    do_reset();
    apply(1'b0, 1'b1, 1'b1, 8'd30); gap(3);
    apply(1'b0, 1'b1, 1'b0, 8'd31); gap(3);
    apply(1'b0, 1'b1, 1'b0, 8'd32); gap(3);
    apply(1'b0, 1'b1, 1'b0, 8'd33);
    check_eq("gap_ch3",  32'(ch3),        32'd33);
    check_eq("gap_done", 32'(frame_done), 32'd1);
    apply(1'b0, 1'b1, 1'b1, 8'd40);
    apply(1'b0, 1'b1, 1'b0, 8'd41);
    apply(1'b1, 1'b1, 1'b0, 8'd42);
    check_eq("rstmid_ch0",  32'(ch0),    32'd0);
    check_eq("rstmid_ch3",  32'(ch3),    32'd0);
    check_eq("rstmid_lock", 32'(locked), 32'd0);

`ifdef TDM_FRAME_LATCH_EN
    // Latched frame publishes all four channels at once
    do_reset();
    apply(1'b0, 1'b1, 1'b1, 8'd12);
    apply(1'b0, 1'b1, 1'b0, 8'd12);
    apply(1'b0, 1'b1, 1'b0, 8'd14);
    check_eq("latch_hold0", 32'(ch0),      32'd0);
    check_eq("latch_holdv", 32'(ch_valid), 32'd0);
    apply(1'b0, 1'b1, 1'b0, 8'd5);
    check_eq("latch_ch0",   32'(ch0),      32'd12);
    check_eq("latch_ch1",   32'(ch1),      32'd12);
    check_eq("latch_ch2",   32'(ch2),      32'd14);
    check_eq("latch_ch3",   32'(ch3),      32'd5);
    check_eq("latch_valid", 32'(ch_valid), 32'hF);
`endif

    // Random traffic: mostly well-formed frames with injected errors and resets
    do_reset();
    for (int c = 0; c < 600; c++) begin
      bit r, v, fs;
      r  = ($urandom_range(0, 59) == 0);
      v  = ($urandom_range(0, 3) != 0);
      if (m_next == 0) fs = ($urandom_range(0, 5) != 0);
      else             fs = ($urandom_range(0, 9) == 0);
      apply(r, v, fs, 8'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/tdm_demux_rx.md
TDM_DEMUX_RX -- requirements
Module: tdm_demux_rx

Interface
REQ-001 SHALL provide parameter W, default 8, giving the data width of every channel.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: synchronous, active-high reset, sampled on the clk rising edge.
REQ-004 SHALL have port din, input, W bits: time-multiplexed data beat.
REQ-005 SHALL have port din_valid, input, 1 bit: din carries a beat this cycle.
REQ-006 SHALL have port frame_sync, input, 1 bit: the current beat is slot 0; ignored when din_valid=0.
REQ-007 SHALL have ports ch0, ch1, ch2, ch3, output, W bits each: registered per-channel data.
REQ-008 SHALL have port ch_valid, output, 4 bits: bit n pulses for one cycle when chn is updated.
REQ-009 SHALL have port frame_done, output, 1 bit: pulses for one cycle when a slot-3 beat is accepted.
REQ-010 SHALL have port locked, output, 1 bit: high in state LOCKED.
REQ-011 SHALL have port sync_err, output, 1 bit: pulses for one cycle on a framing violation.

Function
REQ-012 SHALL implement two states, HUNT and LOCKED, plus a 2-bit slot counter.
REQ-013 In HUNT: a beat with frame_sync=0 SHALL be discarded with no output change.
REQ-014 In HUNT: a beat with frame_sync=1 SHALL be accepted as slot 0, set slot to 1 and move to LOCKED.
REQ-015 In LOCKED: a beat with frame_sync=0 and slot!=0 SHALL be accepted as the current slot, then slot SHALL increment, wrapping 3->0.
REQ-016 In LOCKED: a beat with frame_sync=1 and slot=0 SHALL be accepted normally as slot 0.
REQ-017 In LOCKED: a beat with frame_sync=1 and slot!=0 SHALL pulse sync_err, be accepted as slot 0, set slot to 1 and stay LOCKED (resync).
REQ-018 In LOCKED: a beat with frame_sync=0 and slot=0 SHALL pulse sync_err, be discarded, and move to HUNT.
REQ-019 An accepted beat SHALL appear on its channel output with ch_valid[n]=1 exactly one cycle after the beat (latency 1).
REQ-020 Channels not addressed SHALL hold their value; ch_valid bits SHALL be 0 in every cycle without an update.
REQ-021 frame_done SHALL be asserted in the same cycle as the ch_valid update for slot 3.
REQ-022 Cycles with din_valid=0 SHALL change neither slot nor state, so gaps between beats are allowed.

Reset
REQ-023 While rst=1, all of the following SHALL hold on the next edge:
- ch0..ch3=0, ch_valid=0, frame_done=0, sync_err=0, locked=0.
- slot=0, state=HUNT.
REQ-024 Reset asserted mid-frame SHALL discard the partial frame; rst SHALL take priority over any simultaneous beat.

Configuration
REQ-025 Macro TDM_FRAME_LATCH_EN, when defined, SHALL capture beats into internal staging registers instead of the outputs.
REQ-026 With TDM_FRAME_LATCH_EN defined, a slot-3 accept SHALL update ch0..ch3 together from staging, with ch_valid=4'b1111 and frame_done pulsing.
REQ-027 With TDM_FRAME_LATCH_EN defined, a resync (REQ-017), a return to HUNT (REQ-018) or a reset SHALL discard the staged data with no output update.
REQ-028 With TDM_FRAME_LATCH_EN undefined, each channel SHALL update individually per REQ-019 and no staging registers SHALL exist.

Verification
REQ-029 Bench SHALL cover basic frame: reset, then beats 10(sync),12,15,8 -> ch0..ch3=10,12,15,8; ch_valid pulses 0001,0010,0100,1000; frame_done with the last; locked=1.
REQ-030 Bench SHALL cover hunt: beats 7,9 without sync, then 11(sync),14,13,10 -> the first two are ignored; ch0..ch3=11,14,13,10.
REQ-031 Bench SHALL cover early sync: after slot 1 accepted, beat 5 with frame_sync=1 -> sync_err pulse, ch0=5, locked stays 1, next beat goes to ch1.
REQ-032 Bench SHALL cover missing sync: after a full frame, beat 3 with frame_sync=0 -> sync_err pulse, locked=0, ch0 unchanged.
REQ-033 Bench SHALL cover gaps and reset: din_valid low for 3 cycles between slots -> same outputs as contiguous beats; rst mid-frame -> all outputs 0, locked=0.
REQ-034 Bench SHALL cover latch mode: with TDM_FRAME_LATCH_EN defined, frame 12,12,14,5 -> outputs unchanged until the slot-3 beat, then all four update in one cycle with ch_valid=1111.
